bcd_serial_addsub_ctrl: RTL

//  Digit-serial sequencer for signed sign-magnitude BCD add/subtract on one shared 1-digit BCD adder.
//  - Operates on NDIG-digit operands, 3 digits by default.
//  - Processes the least significant digit first, one digit per clock.
//  - Subtraction uses nines'-complement plus 1.
//  - Re-complements the result when |A|<|B|.
//  - Registers magnitude, sign, overflow and error flags, then pulses done.

---
 rtl/bcd_serial_addsub_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/bcd_serial_addsub_ctrl.sv
// rtl/bcd_serial_addsub_ctrl.sv - digit-serial signed BCD add/subtract sequencer
// One shared 1-digit BCD adder, LSD first; tens'-complement fix-up pass when |A|<|B|.
module bcd_serial_addsub_ctrl #(
    parameter int NDIG = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic              A_sign,
    input  logic [4*NDIG-1:0] A,
    input  logic              B_sign,
    input  logic [4*NDIG-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] Result,
    output logic              R_sign,
    output logic              Ovf,
    output logic              Err
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [4*NDIG-1:0] a_q, b_q, result_q;
    logic              a_sign_q, eff_b_q, sub_q, carry_q;
    logic [IW-1:0]     idx_q;
    logic              r_sign_q, ovf_q, err_q, busy_q, done_q;

    logic [3:0]        a_dig, b_dig, r_dig, in_a, in_b, dig;
    logic [4:0]        sum;
    logic              dig_carry, last;
    logic [4*NDIG-1:0] result_d;
    logic              result_nz_d;

    function automatic logic has_bad_digit(input logic [4*NDIG-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (v[4*k +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Shared digit adder: RUN adds A with B or 9-B; FIX complements the stored result digit.
    always_comb begin
        a_dig = a_q[idx_q*4 +: 4];
        b_dig = b_q[idx_q*4 +: 4];
        r_dig = result_q[idx_q*4 +: 4];
        if (state_q == S_FIX) begin
            in_a = 4'd9 - r_dig;
            in_b = 4'd0;
        end else begin
            in_a = a_dig;
            in_b = sub_q ? (4'd9 - b_dig) : b_dig;
        end
        sum       = {1'b0, in_a} + {1'b0, in_b} + {4'b0000, carry_q};
        dig_carry = (sum > 5'd9);
        dig       = dig_carry ? (sum[3:0] + 4'd6) : sum[3:0];
        result_d  = result_q;
        result_d[idx_q*4 +: 4] = dig;
        result_nz_d = (result_d != '0);
        last = (idx_q == IW'(NDIG - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            a_sign_q <= 1'b0;
            eff_b_q  <= 1'b0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            r_sign_q <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= A;
                        b_q      <= B;
                        a_sign_q <= A_sign;
                        eff_b_q  <= B_sign ^ op;
                        sub_q    <= A_sign ^ (B_sign ^ op);
                        ovf_q    <= 1'b0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (has_bad_digit(a_q) || has_bad_digit(b_q)) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                        r_sign_q <= 1'b0;
                        ovf_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        idx_q   <= '0;
                        carry_q <= sub_q;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q <= result_d;
                    carry_q  <= dig_carry;
                    idx_q    <= idx_q + 1'b1;
                    if (last) begin
                        idx_q <= '0;
                        if (!sub_q || dig_carry) begin
                            // Sign is taken from A, but a zero magnitude is always positive.
                            r_sign_q <= a_sign_q & result_nz_d;
                            ovf_q    <= ~sub_q & dig_carry;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            carry_q <= 1'b1;
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    result_q <= result_d;
                    carry_q  <= dig_carry;
                    idx_q    <= idx_q + 1'b1;
                    if (last) begin
                        idx_q    <= '0;
                        r_sign_q <= eff_b_q & result_nz_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Result = result_q;
    assign R_sign = r_sign_q;
    assign Ovf    = ovf_q;
    assign Err    = err_q;

endmodule
